// File: rtl/addsub_ctrl_pkg.sv
// Shared width default and FSM state encodings for the add/subtract sequencing stage.
package addsub_ctrl_pkg;

    localparam int ADDSUB_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } state_t;

endpackage

// File: rtl/addsub_ctrl.sv
// Operand capture and sequencing for an external ripple adder; result registered one cycle
// after go is accepted, done pulses the cycle after. Requests not legal in the current state are dropped.
module addsub_ctrl
    import addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             op_sub,
    input  logic             go,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [3:0]       op_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_vld_q, a_vld_d;
    logic             b_vld_q, b_vld_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       cnt_q, cnt_d;

    // Subtract is A + ~B + 1; the adder sees the effective B for the whole EXEC cycle.
    assign add_a   = a_q;
    assign add_b   = op_q ? ~b_q : b_q;
    assign add_cin = op_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a_vld_d  = a_vld_q;
        b_vld_d  = b_vld_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_a) begin
                    a_d     = din;
                    a_vld_d = 1'b1;
                end
                if (load_b) begin
                    b_d     = din;
                    b_vld_d = 1'b1;
                end
                if (go && a_vld_q && b_vld_q && !load_a && !load_b) begin
                    state_d = ST_EXEC;
                    op_d    = op_sub;
                end
            end
            ST_EXEC: begin
                state_d  = ST_DONE;
                result_d = add_sum;
                carry_d  = add_cout;
                ovf_d    = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != add_a[WIDTH-1]);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            op_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign op_count = cnt_q;

endmodule

// File: tb/tb_addsub_ctrl.sv
// Directed bench for addsub_ctrl with a behavioural 4-bit adder closing the add_* loop.
module tb_addsub_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       load_a, load_b, op_sub, go;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    logic [3:0] result;
    logic       carry, overflow, busy, done;
    logic [3:0] op_count;
    logic [4:0] full_sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign full_sum = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_sum  = full_sum[3:0];
    assign add_cout = full_sum[4];

    addsub_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .load_a   (load_a),
        .load_b   (load_b),
        .op_sub   (op_sub),
        .go       (go),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .op_count (op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b);
        din = a; load_a = 1'b1; step();
        load_a = 1'b0; din = b; load_b = 1'b1; step();
        load_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; din = 4'd0; load_a = 1'b0; load_b = 1'b0; op_sub = 1'b0; go = 1'b0;
        step(); step();
        chk("rst_result", {4'd0, result}, 8'h00);
        chk("rst_flags", {3'd0, carry, overflow, busy, done, add_cin}, 8'h00);
        chk("rst_count", {4'd0, op_count}, 8'h00);
        chk("rst_adder", {add_a, add_b}, 8'h00);
        reset = 1'b0;

        // 3 + 4
        load(4'b0011, 4'b0100);
        go = 1'b1; op_sub = 1'b0; step(); go = 1'b0;
        chk("add_exec_busy", {6'd0, busy, done}, 8'h02);
        step();
        chk("add_done", {6'd0, busy, done}, 8'h03);
        chk("add_result", {2'd0, carry, overflow, result}, 8'h07);
        step();
        chk("add_idle", {6'd0, busy, done}, 8'h00);
        chk("add_count", {4'd0, op_count}, 8'h01);

        // 7 + 1 overflows signed range
        load(4'b0111, 4'b0001);
        go = 1'b1; step(); go = 1'b0; step();
        chk("ovf_result", {2'd0, carry, overflow, result}, 8'h18);
        step();
        chk("ovf_count", {4'd0, op_count}, 8'h02);

        // 2 - 5 borrows
        load(4'b0010, 4'b0101);
        go = 1'b1; op_sub = 1'b1; step(); go = 1'b0; op_sub = 1'b0;
        chk("sub_exec_adder", {3'd0, add_cin, add_b}, 8'h1a);
        step();
        chk("sub_result", {2'd0, carry, overflow, result}, 8'h0d);
        step();
        chk("sub_count", {4'd0, op_count}, 8'h03);

        // Clear valid flags, then exercise ignored requests
        reset = 1'b1; step(); reset = 1'b0;
        din = 4'd5; load_a = 1'b1; step(); load_a = 1'b0;
        go = 1'b1; step(); go = 1'b0;
        chk("go_only_a", {7'd0, busy}, 8'h00);
        din = 4'd6; load_b = 1'b1; go = 1'b1; step(); load_b = 1'b0; go = 1'b0;
        chk("go_with_load", {7'd0, busy}, 8'h00);
        chk("load_b_taken", {4'd0, add_b}, 8'h06);

        go = 1'b1; step();
        chk("legal_go_exec", {6'd0, busy, done}, 8'h02);
        step(); go = 1'b0;
        chk("go_in_exec", {6'd0, busy, done}, 8'h03);
        chk("exec_result", {4'd0, result}, 8'h0b);
        din = 4'hf; load_a = 1'b1; step(); load_a = 1'b0;
        chk("load_in_done", {4'd0, add_a}, 8'h05);
        chk("after_done", {3'd0, op_count, busy}, 8'h02);
        step();
        chk("no_retrigger", {6'd0, busy, done}, 8'h00);

        // Reset while in EXEC
        go = 1'b1; step(); go = 1'b0;
        chk("mid_exec_busy", {7'd0, busy}, 8'h01);
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_state", {2'd0, busy, done, result}, 8'h00);
        step();
        chk("abort_no_done", {6'd0, busy, done}, 8'h00);
        chk("abort_count", {4'd0, op_count}, 8'h00);

        // Sixteen operations wrap the counter
        load(4'b0001, 4'b0001);
        for (int i = 0; i < 16; i++) begin
            go = 1'b1; step(); go = 1'b0; step(); step();
            if (i == 14) chk("count_15", {4'd0, op_count}, 8'h0f);
        end
        chk("count_wrap", {4'd0, op_count}, 8'h00);
        chk("wrap_result", {4'd0, result}, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
